// File: rtl/gray_pkg.sv
// Shared definitions for the RGB565 -> 8-bit grayscale ISE and its converter.
// Optional build macro GRAY4_SEQ_ROUND_EN (round-to-nearest) is consumed by
// rgb565_to_gray8.
package gray_pkg;

  // Sequencer state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Luma weights scaled so that they sum to 256.
  localparam logic [7:0] COEF_R = 8'd54;
  localparam logic [7:0] COEF_G = 8'd183;
  localparam logic [7:0] COEF_B = 8'd19;

  // RGB565 field positions.
  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  // Constant-coefficient multiply written as a shift-add chain; with a
  // constant k only the set bits produce adders.
  function automatic logic [15:0] mul_const(input logic [7:0] x,
                                            input logic [7:0] k);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc + ({8'd0, x} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rgb565_to_gray8.sv
// Combinational single-pixel RGB565 -> 8-bit grayscale converter.
// Build macro GRAY4_SEQ_ROUND_EN: when defined, adds 128 before dropping the
// low byte (round to nearest); otherwise the low byte is truncated.
module rgb565_to_gray8
  import gray_pkg::*;
(
  input  logic [15:0] pixel_i,
  output logic [7:0]  gray_o
);

  logic [4:0]  r5;
  logic [5:0]  g6;
  logic [4:0]  b5;
  logic [7:0]  r8;
  logic [7:0]  g8;
  logic [7:0]  b8;
  logic [15:0] sum;
`ifdef GRAY4_SEQ_ROUND_EN
  logic [16:0] rounded;
`endif

  // Expand each channel to 8 bits by replicating its MSBs, then weight and sum.
  always_comb begin
    r5  = pixel_i[R_MSB:R_LSB];
    g6  = pixel_i[G_MSB:G_LSB];
    b5  = pixel_i[B_MSB:B_LSB];
    r8  = {r5, r5[4:2]};
    g8  = {g6, g6[5:4]};
    b8  = {b5, b5[4:2]};
    sum = mul_const(r8, COEF_R) + mul_const(g8, COEF_G) + mul_const(b8, COEF_B);
  end

`ifdef GRAY4_SEQ_ROUND_EN
  // Round to nearest; the weights cap the sum at 65280, so bit 16 never sets.
  always_comb begin
    rounded = {1'b0, sum} + 17'd128;
    gray_o  = 8'(rounded >> 8);
  end
`else
  // Truncate: the gray value is the high byte of the weighted sum.
  always_comb begin
    gray_o = 8'(sum >> 8);
  end
`endif

endmodule

// File: rtl/rgb565_gray4_sequencer.sv
// Multi-cycle custom-instruction unit: converts four RGB565 pixels (two per
// operand word) into four grayscale bytes using one shared converter, one
// pixel per cycle. Rounding is selected with build macro GRAY4_SEQ_ROUND_EN
// (see rgb565_to_gray8).
//
// Handshake: a request is start=1 with iseId==customId, sampled only while
// the FSM is IDLE; requests in RUN/DONE are dropped. done is a one-cycle pulse
// five cycles after acceptance, and result carries the packed bytes only in
// that cycle (zero otherwise) so it can be OR-combined with other ISEs.
module rgb565_gray4_sequencer
  import gray_pkg::*;
#(
  parameter logic [7:0] customId = 8'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  iseId,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  output logic        done,
  output logic [31:0] result,
  output logic [1:0]  dbg_state
);

  state_e           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [31:0]      op_a_q, op_a_d;
  logic [31:0]      op_b_q, op_b_d;
  logic [3:0][7:0]  bytes_q, bytes_d;

  logic             sel;
  logic [15:0]      pixel;
  logic [7:0]       gray;

  // Request decode.
  always_comb begin
    sel = start & (iseId == customId);
  end

  // Select the pixel for the current step from the latched operands.
  always_comb begin
    pixel = op_a_q[15:0];
    case (idx_q)
      2'd0: pixel = op_a_q[15:0];
      2'd1: pixel = op_a_q[31:16];
      2'd2: pixel = op_b_q[15:0];
      2'd3: pixel = op_b_q[31:16];
    endcase
  end

  rgb565_to_gray8 u_conv (
    .pixel_i (pixel),
    .gray_o  (gray)
  );

  // Next-state logic: accept in IDLE, four conversion steps in RUN, one DONE cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    bytes_d = bytes_q;
    case (state_q)
      IDLE: begin
        if (sel) begin
          op_a_d  = valueA;
          op_b_d  = valueB;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        bytes_d[idx_q] = gray;
        if (idx_q == 2'd3) begin
          idx_d   = 2'd0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      bytes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      bytes_q <= bytes_d;
    end
  end

  // Outputs: result is gated so the bus sees zero outside the done pulse.
  always_comb begin
    done      = (state_q == DONE);
    result    = done ? bytes_q : 32'd0;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_rgb565_gray4_sequencer.sv
// Directed bench for rgb565_gray4_sequencer. Expected results are hand
// computed for both settings of GRAY4_SEQ_ROUND_EN.
module tb_rgb565_gray4_sequencer;

  localparam logic [7:0] CUSTOM_ID = 8'h5A;

  // Hand-computed packed results {gray3, gray2, gray1, gray0}.
  // Per-pixel grays (trunc / round): 0000:00/00 FFFF:FF/FF F800:35/36
  // 07E0:B6/B6 001F:12/13 0001:00/01 0020:02/03 0800:01/02 8410:82/83
`ifdef GRAY4_SEQ_ROUND_EN
  localparam logic [31:0] EXP_EXTREME = 32'hB636_FF00;
  localparam logic [31:0] EXP_MIX1    = 32'h8302_0301;
  localparam logic [31:0] EXP_MIX2    = 32'hFFB6_1336;
  localparam logic [31:0] EXP_LSB     = 32'h0000_0001;
  localparam logic [31:0] EXP_MIX3    = 32'h8303_0201;
`else
  localparam logic [31:0] EXP_EXTREME = 32'hB635_FF00;
  localparam logic [31:0] EXP_MIX1    = 32'h8201_0200;
  localparam logic [31:0] EXP_MIX2    = 32'hFFB6_1235;
  localparam logic [31:0] EXP_LSB     = 32'h0000_0000;
  localparam logic [31:0] EXP_MIX3    = 32'h8202_0100;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ise_id = 8'h00;
  logic [31:0] value_a = '0;
  logic [31:0] value_b = '0;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];

  rgb565_gray4_sequencer #(.customId(CUSTOM_ID)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .iseId     (ise_id),
    .valueA    (value_a),
    .valueB    (value_b),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock and cycle counter.
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expectation; outside done result must be 0.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=%h expected no done (cycle %0d)", result, cyc);
      end else begin
        check("done_result", result, exp_q.pop_front());
        check("done_cycle", cyc, due_q.pop_front());
      end
    end else begin
      check("idle_result_zero", result, 32'd0);
    end
  end

  // Driver: one-cycle start strobe; operands are scrambled right after the
  // accept edge so late input changes would corrupt a wrong result.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] id,
                       input logic accept, input logic [31:0] exp);
    @(negedge clock);
    start   = 1'b1;
    ise_id  = id;
    value_a = a;
    value_b = b;
    @(posedge clock);
    #1;
    start   = 1'b0;
    value_a = ~a;
    value_b = ~b;
    if (accept) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 4);
    end
  endtask

  // Bounded wait for all outstanding results.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
    exp_q.delete();
    due_q.delete();
  endtask

  task automatic quiet(input int n);
    repeat (n) begin
      @(negedge clock);
      check("quiet_done", {31'd0, done}, 32'd0);
      check("quiet_state", {30'd0, dbg_state}, 32'd0);
    end
  endtask

  initial begin
    // Reset held low: outputs zero, FSM idle.
    #12;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    quiet(10);

    // Directed conversions.
    issue(32'hFFFF_0000, 32'h07E0_F800, CUSTOM_ID, 1'b1, EXP_EXTREME);
    drain(20);
    issue(32'h0020_0001, 32'h8410_0800, CUSTOM_ID, 1'b1, EXP_MIX1);
    drain(20);
    issue(32'h001F_F800, 32'hFFFF_07E0, CUSTOM_ID, 1'b1, EXP_MIX2);
    drain(20);
    issue(32'h0000_0001, 32'h0000_0000, CUSTOM_ID, 1'b1, EXP_LSB);
    drain(20);

    // Non-matching id is ignored.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h5B, 1'b0, 32'd0);
    quiet(8);

    // Second request while busy (cycle T+2) is dropped.
    issue(32'h0020_0001, 32'h8410_0800, CUSTOM_ID, 1'b1, EXP_MIX1);
    @(posedge clock);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, CUSTOM_ID, 1'b0, 32'd0);
    drain(20);
    quiet(4);

    // Back-to-back at the minimum 6-cycle interval.
    issue(32'h001F_F800, 32'hFFFF_07E0, CUSTOM_ID, 1'b1, EXP_MIX2);
    repeat (5) @(posedge clock);
    issue(32'hFFFF_0000, 32'h07E0_F800, CUSTOM_ID, 1'b1, EXP_EXTREME);
    drain(20);
    quiet(2);

    // Reset in cycle T+3 aborts the operation with no done pulse.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, CUSTOM_ID, 1'b1, 32'hFFFF_FFFF);
    @(posedge clock);
    @(posedge clock);
    #2;
    reset = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    quiet(6);
    issue(32'h0800_0001, 32'h8410_0020, CUSTOM_ID, 1'b1, EXP_MIX3);
    drain(20);
    quiet(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
